// File: rtl/digit_recog_pkg.sv
// Shared constants for the digit recogniser: digit templates, 7-segment table, counter width.
package digit_recog_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] DIGIT_NONE = 4'hF;

  localparam logic [8:0] TMPL_0 = 9'h1EF;
  localparam logic [8:0] TMPL_1 = 9'h092;
  localparam logic [8:0] TMPL_2 = 9'h193;
  localparam logic [8:0] TMPL_3 = 9'h1F7;
  localparam logic [8:0] TMPL_4 = 9'h13D;
  localparam logic [8:0] TMPL_5 = 9'h0D6;
  localparam logic [8:0] TMPL_6 = 9'h1F9;
  localparam logic [8:0] TMPL_7 = 9'h127;
  localparam logic [8:0] TMPL_8 = 9'h1FF;
  localparam logic [8:0] TMPL_9 = 9'h13F;

  localparam logic [9:0][8:0] DIGIT_TMPL = {
    TMPL_9, TMPL_8, TMPL_7, TMPL_6, TMPL_5,
    TMPL_4, TMPL_3, TMPL_2, TMPL_1, TMPL_0
  };

  // Active-low {dp,g,f,e,d,c,b,a}, index = digit
  localparam logic [9:0][7:0] DIGIT_SEG = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    if (d <= 4'd9) return DIGIT_SEG[d];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/digit_code_lut.sv
// Combinational exact matcher of a 9-bit 3x3 feature code against the ten digit templates.
module digit_code_lut
  import digit_recog_pkg::*;
(
  input  logic [8:0] code_i,
  output logic       hit_o,
  output logic [3:0] digit_o
);

  always_comb begin
    hit_o   = 1'b0;
    digit_o = DIGIT_NONE;
    for (int unsigned i = 0; i < 10; i++) begin
      if (code_i == DIGIT_TMPL[i]) begin
        hit_o   = 1'b1;
        digit_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/digit_code_recognizer.sv
// Per-frame digit recogniser with hit/loss debounce filter.
// Optional 7-segment output enabled by defining DIGIT_SEG_EN.
module digit_code_recognizer
  import digit_recog_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned LOST_FRAMES   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_vs,
  input  logic [8:0] feature_code,
  output logic [3:0] o_digit,
  output logic       o_valid,
  output logic       o_change,
  output logic       o_hit
`ifdef DIGIT_SEG_EN
  ,
  output logic [7:0] o_seg
`endif
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0] LOST_C   = CNT_W'(LOST_FRAMES);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic             vs_d_q;
  logic             s1_v_q;
  logic [8:0]       code_q;
  logic             s2_v_q;
  logic             s2_hit_q;
  logic [3:0]       s2_digit_q;
  logic             lut_hit;
  logic [3:0]       lut_digit;

  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             change_q, change_d;
  logic             hit_q;

  logic             frame_end;
  assign frame_end = vs_d_q & ~i_vs;

  digit_code_lut u_lut (
    .code_i  (code_q),
    .hit_o   (lut_hit),
    .digit_o (lut_digit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      code_q     <= '0;
      s2_v_q     <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_digit_q <= DIGIT_NONE;
    end else begin
      vs_d_q     <= i_vs;
      s1_v_q     <= frame_end;
      if (frame_end) code_q <= feature_code;
      s2_v_q     <= s1_v_q;
      s2_hit_q   <= lut_hit;
      s2_digit_q <= lut_digit;
    end
  end

  // Publish/withdraw decisions use the post-update counters, so they are
  // evaluated on the _d values within the same cycle.
  always_comb begin
    cand_d  = cand_q;
    stab_d  = stab_q;
    miss_d  = miss_q;
    digit_d = digit_q;
    valid_d = valid_q;
    if (s2_v_q) begin
      if (s2_hit_q) begin
        miss_d = '0;
        if (s2_digit_q == cand_q) begin
          stab_d = (stab_q >= STABLE_C) ? STABLE_C : stab_q + ONE_C;
        end else begin
          cand_d = s2_digit_q;
          stab_d = ONE_C;
        end
        if (stab_d == STABLE_C) begin
          digit_d = cand_d;
          valid_d = 1'b1;
        end
      end else begin
        cand_d = DIGIT_NONE;
        stab_d = '0;
        miss_d = (miss_q >= LOST_C) ? LOST_C : miss_q + ONE_C;
        if (miss_d == LOST_C) begin
          digit_d = DIGIT_NONE;
          valid_d = 1'b0;
        end
      end
    end
    change_d = s2_v_q && ({valid_d, digit_d} != {valid_q, digit_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q   <= DIGIT_NONE;
      stab_q   <= '0;
      miss_q   <= '0;
      digit_q  <= DIGIT_NONE;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      miss_q   <= miss_d;
      digit_q  <= digit_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      if (s2_v_q) hit_q <= s2_hit_q;
    end
  end

  assign o_digit  = digit_q;
  assign o_valid  = valid_q;
  assign o_change = change_q;
  assign o_hit    = hit_q;

`ifdef DIGIT_SEG_EN
  logic [7:0] seg_q;

  always_ff @(posedge clk) begin
    if (rst) seg_q <= SEG_BLANK;
    else     seg_q <= seg_of(digit_d);
  end

  assign o_seg = seg_q;
`endif

endmodule

// File: tb/tb_digit_code_recognizer.sv
// Randomised bench for digit_code_recognizer with a frame-history reference model.
module tb_digit_code_recognizer;

  localparam int STABLE = 3;
  localparam int LOST   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_vs = 1'b0;
  logic [8:0] feature_code = '0;
  logic [3:0] o_digit;
  logic       o_valid;
  logic       o_change;
  logic       o_hit;
`ifdef DIGIT_SEG_EN
  logic [7:0] o_seg;
`endif

  int checks = 0;
  int errors = 0;
  int chg_seen = 0;

  always #5 clk = ~clk;

  digit_code_recognizer #(
    .STABLE_FRAMES (STABLE),
    .LOST_FRAMES   (LOST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_vs         (i_vs),
    .feature_code (feature_code),
    .o_digit      (o_digit),
    .o_valid      (o_valid),
    .o_change     (o_change),
    .o_hit        (o_hit)
`ifdef DIGIT_SEG_EN
    ,
    .o_seg        (o_seg)
`endif
  );

  function automatic int lookup(input logic [8:0] c);
    case (c)
      9'h1EF: return 0;
      9'h092: return 1;
      9'h193: return 2;
      9'h1F7: return 3;
      9'h13D: return 4;
      9'h0D6: return 5;
      9'h1F9: return 6;
      9'h127: return 7;
      9'h1FF: return 8;
      9'h13F: return 9;
      default: return 15;
    endcase
  endfunction

  function automatic logic [7:0] seg_ref(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Reference model: decisions come from the trailing run in the frame history.
  logic [3:0] exp_digit = 4'hF;
  logic       exp_valid = 1'b0;
  logic       exp_change = 1'b0;
  logic       exp_hit = 1'b0;
  bit         armed = 1'b0;
  bit         vs_prev = 1'b0;
  bit         st1_v = 1'b0, st2_v = 1'b0;
  logic [8:0] st1_c = '0, st2_c = '0;
  int         hist[$];

  always @(posedge clk) begin
    bit         fe;
    logic [8:0] c;
    fe = vs_prev && !i_vs;
    c  = feature_code;
    if (rst) begin
      armed = 1'b1;
      vs_prev = 1'b0;
      st1_v = 1'b0; st2_v = 1'b0;
      hist.delete();
      exp_digit = 4'hF; exp_valid = 1'b0; exp_change = 1'b0; exp_hit = 1'b0;
    end else begin
      vs_prev = i_vs;
      exp_change = 1'b0;
      if (st2_v) begin
        int d, run;
        logic [4:0] old;
        d = lookup(st2_c);
        exp_hit = (d != 15);
        hist.push_back(d);
        if (hist.size() > 32) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i] != d) break;
          run++;
        end
        old = {exp_valid, exp_digit};
        if (d != 15 && run >= STABLE) begin
          exp_valid = 1'b1; exp_digit = 4'(d);
        end else if (d == 15 && run >= LOST) begin
          exp_valid = 1'b0; exp_digit = 4'hF;
        end
        exp_change = ({exp_valid, exp_digit} != old);
      end
      st2_v = st1_v; st2_c = st1_c;
      st1_v = fe;    st1_c = c;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (o_digit !== exp_digit) begin
        errors++; $display("FAIL digit: got %h want %h @%0t", o_digit, exp_digit, $time);
      end
      checks++;
      if (o_valid !== exp_valid) begin
        errors++; $display("FAIL valid: got %b want %b @%0t", o_valid, exp_valid, $time);
      end
      checks++;
      if (o_change !== exp_change) begin
        errors++; $display("FAIL change: got %b want %b @%0t", o_change, exp_change, $time);
      end
      checks++;
      if (o_hit !== exp_hit) begin
        errors++; $display("FAIL hit: got %b want %b @%0t", o_hit, exp_hit, $time);
      end
`ifdef DIGIT_SEG_EN
      checks++;
      if (o_seg !== seg_ref(int'(exp_digit))) begin
        errors++; $display("FAIL seg: got %h want %h @%0t", o_seg, seg_ref(int'(exp_digit)), $time);
      end
`endif
      if (o_change === 1'b1) chg_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [8:0] c, input int hi, input int lo);
    feature_code = c;
    i_vs = 1'b1;
    tick(hi);
    i_vs = 1'b0;
    tick(lo);
  endtask

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    logic [8:0] cur;
    tick(3);
    rst = 1'b0;
    tick(1);

    // i_vs low across reset release: nothing happens
    tick(8);
    lit("idle_valid", int'(o_valid), 0);
    lit("idle_digit", int'(o_digit), 15);
    lit("idle_change_cnt", chg_seen, 0);

    // Three frames of digit 1 publish, a fourth gives no pulse
    frame(9'h092, 2, 4);
    frame(9'h092, 2, 4);
    lit("pre_pub_valid", int'(o_valid), 0);
    frame(9'h092, 2, 4);
    lit("pub1_digit", int'(o_digit), 1);
    lit("pub1_valid", int'(o_valid), 1);
    lit("pub1_changes", chg_seen, 1);
    frame(9'h092, 2, 4);
    lit("reconfirm_changes", chg_seen, 1);

    // Other digit interrupts briefly: output holds
    frame(9'h1F7, 2, 4);
    frame(9'h1F7, 2, 4);
    frame(9'h092, 2, 4);
    lit("hold_digit", int'(o_digit), 1);
    lit("hold_changes", chg_seen, 1);

    // Publish 8, then five misses withdraw it
    for (int i = 0; i < 3; i++) frame(9'h1FF, 2, 4);
    lit("pub8_digit", int'(o_digit), 8);
    lit("pub8_changes", chg_seen, 2);
`ifdef DIGIT_SEG_EN
    lit("pub8_seg", int'(o_seg), 'h80);
`endif
    for (int i = 0; i < 5; i++) begin
      frame(9'h000, 2, 4);
      lit("miss_hit", int'(o_hit), 0);
      if (i < 4) lit("miss_hold_valid", int'(o_valid), 1);
    end
    lit("lost_valid", int'(o_valid), 0);
    lit("lost_digit", int'(o_digit), 15);
    lit("lost_changes", chg_seen, 3);
`ifdef DIGIT_SEG_EN
    lit("lost_seg", int'(o_seg), 'hFF);
    for (int i = 0; i < 3; i++) frame(9'h1EF, 2, 4);
    lit("pub0_seg", int'(o_seg), 'hC0);
    for (int i = 0; i < 5; i++) frame(9'h000, 2, 4);
`endif

    // Reset one cycle after a frame end discards the in-flight frame
    frame(9'h092, 2, 4);
    frame(9'h092, 2, 4);
    feature_code = 9'h092;
    i_vs = 1'b1;
    tick(2);
    i_vs = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);
    lit("rst_mid_valid", int'(o_valid), 0);
    frame(9'h092, 2, 4);
    lit("rst_cnt_cleared", int'(o_valid), 0);

    // Back-to-back closely spaced frames then random traffic
    do_reset();
    base = chg_seen;
    for (int i = 0; i < 3; i++) frame(9'h13F, 1, 1);
    tick(3);
    lit("b2b_digit", int'(o_digit), 9);
    lit("b2b_changes", chg_seen - base, 1);

    cur = 9'h193;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) cur = 9'($urandom);
      else if (r < 25) begin
        logic [8:0] t [10];
        t = '{9'h1EF, 9'h092, 9'h193, 9'h1F7, 9'h13D, 9'h0D6, 9'h1F9, 9'h127, 9'h1FF, 9'h13F};
        cur = t[$urandom_range(0, 9)];
      end else if (r < 32) cur = 9'h000;
      if ($urandom_range(0, 99) < 2) do_reset();
      frame(cur, $urandom_range(1, 4), $urandom_range(1, 4));
    end
    tick(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
